// File: rtl/edge_gen_pkg.sv
// Shared types and helpers for the edge pulse generator.
//   state_t : FSM encoding (IDLE, HIGH, GAP)
//   cnt_w   : width of a counter that must hold values 0..n (at least 1 bit)
package edge_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int cnt_w(int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter used to time the HIGH and GAP phases.
// Ports:
//   clk      in  clock
//   rst      in  asynchronous active-high reset (count returns to 0)
//   load     in  load load_val this cycle (takes priority over counting)
//   load_val in  W-bit value loaded; the phase then lasts load_val+1 cycles
//   expire   out count is zero, i.e. the current cycle is the last of the phase
module pulse_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/edge_pulse_gen.sv
// Transmit side of the single-wire edge-signalling link. Each accepted 1-cycle request
// becomes one rectangular pulse on 'signal' (HIGH_CYCLES high, then at least GAP_CYCLES low),
// so a rising-edge detector downstream sees exactly one edge per accepted request.
// Requests arriving while a pulse is in progress are queued; excess ones are dropped.
// Ports:
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   req      in  event request, sampled each posedge
//   clr_ovf  in  clears the sticky overflow flag (a simultaneous new drop wins)
//   signal   out registered pulse train
//   busy     out pulse in progress or requests queued
//   done     out registered 1-cycle strobe on the first low cycle after a pulse
//   pending  out registered queued-request count
//   overflow out registered sticky flag: a request was dropped
module edge_pulse_gen
  import edge_gen_pkg::*;
#(
  parameter int HIGH_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_DEPTH  = 4,
  localparam int PW         = cnt_w(PEND_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          clr_ovf,
  output logic          signal,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  if (HIGH_CYCLES < 1) begin : g_bad_high
    $error("edge_pulse_gen: HIGH_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("edge_pulse_gen: GAP_CYCLES must be >= 1");
  end
  if (PEND_DEPTH < 1) begin : g_bad_depth
    $error("edge_pulse_gen: PEND_DEPTH must be >= 1");
  end

  localparam int MaxCyc = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int TW     = cnt_w(MaxCyc);

  localparam logic [TW-1:0] HighLoad = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] GapLoad  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PendMax  = PW'(PEND_DEPTH);

  state_t          state_q, state_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic            overflow_q, overflow_d;
  logic            signal_q, signal_d;
  logic            done_q, done_d;

  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_expire;
  logic            enq, deq, drop;

  pulse_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Next-state logic. The timer is reloaded on every phase entry, so it only needs
  // to be consulted while in HIGH or GAP.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    deq      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = HighLoad;
        end
      end
      HIGH: begin
        if (tmr_expire) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GapLoad;
        end
      end
      GAP: begin
        if (tmr_expire) begin
          if (pending_q != '0) begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = HighLoad;
            deq      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A req in IDLE starts a pulse directly; anywhere else it goes to the queue.
  // A dequeue on the same edge frees a slot, so a full queue does not overflow then.
  always_comb begin
    enq       = req && (state_q != IDLE);
    drop      = enq && (pending_q == PendMax) && !deq;
    pending_d = pending_q;
    if (enq && !drop && !deq) begin
      pending_d = pending_q + PW'(1);
    end else if (deq && !enq) begin
      pending_d = pending_q - PW'(1);
    end
    overflow_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
    signal_d   = (state_d == HIGH);
    done_d     = (state_q == HIGH) && (state_d == GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      signal_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      signal_q   <= signal_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(state_q == IDLE && pending_q != '0))
        else $error("edge_pulse_gen: IDLE with non-empty queue");
    end
  end

  assign signal   = signal_q;
  assign done     = done_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || (pending_q != '0);

endmodule
